// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// bus widths and the output polarity helper.
package seg7_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  // Active-high glyphs, bit 0 = segment a ... bit 6 = segment g
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic apply_polarity(input logic v, input bit active_low);
    return v ^ active_low;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-data load bus: application logic (master) presents digit data
// and a one-cycle load strobe to the scan driver (slave).
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS = 4
);
  import seg7_pkg::*;

  logic [NIBBLE_W*DIGITS-1:0] value_in;
  logic [DIGITS-1:0]          dp_in;
  logic [DIGITS-1:0]          digit_en;
  logic                       load;

  modport master (output value_in, dp_in, digit_en, load);
  modport slave  (input  value_in, dp_in, digit_en, load);

endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex nibble to active-high seven-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    segs
);

  always_comb segs = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver with frame-synchronous double buffer.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus,
  output logic [SEG_W-1:0]    seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                frame_tick
);

  localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic        OFF = apply_polarity(1'b0, ACTIVE_LOW);

  logic [PW-1:0]                presc;
  logic [IW-1:0]                idx;
  logic                         step;
  logic                         wrap;

  logic [NIBBLE_W*DIGITS-1:0]   act_val, pend_val;
  logic [DIGITS-1:0]            act_dp, act_en, pend_dp, pend_en;
  logic                         pend_valid;

  logic [NIBBLE_W-1:0]          nib;
  logic [SEG_W-1:0]             glyph;
  logic                         show;
  logic [SEG_W-1:0]             seg_n;
  logic                         dp_n;
  logic [DIGITS-1:0]            an_n;

  always_comb begin
    step = (presc == PW'(DIV - 1));
    wrap = step && (idx == IW'(DIGITS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_valid <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (step) begin
        presc <= '0;
        idx   <= wrap ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      // A load landing on the wrap edge bypasses pending and goes straight live
      if (wrap && bus.load) begin
        act_val    <= bus.value_in;
        act_dp     <= bus.dp_in;
        act_en     <= bus.digit_en;
        pend_valid <= 1'b0;
      end else if (wrap && pend_valid) begin
        act_val    <= pend_val;
        act_dp     <= pend_dp;
        act_en     <= pend_en;
        pend_valid <= 1'b0;
      end else if (bus.load) begin
        pend_val   <= bus.value_in;
        pend_dp    <= bus.dp_in;
        pend_en    <= bus.digit_en;
        pend_valid <= 1'b1;
      end
    end
  end

  always_comb nib = act_val[idx*NIBBLE_W +: NIBBLE_W];

  seg7_hex_decode u_dec (
    .nibble (nib),
    .segs   (glyph)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_blank;
  logic              zero_above;

  // Walk from the most significant digit down, tracking whether every
  // enabled digit seen so far was zero.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((DIGITS - 1 - i) != 0 && zero_above && !act_dp[DIGITS-1-i] &&
          act_val[(DIGITS-1-i)*NIBBLE_W +: NIBBLE_W] == '0)
        lz_blank[DIGITS-1-i] = 1'b1;
      if (act_en[DIGITS-1-i] && act_val[(DIGITS-1-i)*NIBBLE_W +: NIBBLE_W] != '0)
        zero_above = 1'b0;
    end
  end

  always_comb show = act_en[idx] && !lz_blank[idx];
`else
  always_comb show = act_en[idx];
`endif

  always_comb begin
    seg_n = '0;
    an_n  = '0;
    for (int unsigned i = 0; i < SEG_W; i++)
      seg_n[i] = apply_polarity(show && glyph[i], ACTIVE_LOW);
    for (int unsigned i = 0; i < DIGITS; i++)
      an_n[i] = apply_polarity(show && (idx == IW'(i)), ACTIVE_LOW);
    dp_n = apply_polarity(show && act_dp[idx], ACTIVE_LOW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= {SEG_W{OFF}};
      dp  <= OFF;
      an  <= {DIGITS{OFF}};
    end else begin
      seg <= seg_n;
      dp  <= dp_n;
      an  <= an_n;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (DIGITS=4, DIV=4, active-low).
module tb_seg7_scan_driver;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg7_scan_driver_if #(.DIGITS(4)) bus_if ();

  seg7_scan_driver #(
    .DIGITS     (4),
    .CLK_HZ     (8),
    .REFRESH_HZ (2),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if.slave),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {frame_tick, an, dp, seg} at negedge i of a frame that starts
  // right after a frame_tick (or reset release): digit (i%16)/4 is shown.
  function automatic logic [12:0] model(input int unsigned i, input logic [15:0] v,
                                        input logic [3:0] dpv, input logic [3:0] en);
    int unsigned d;
    logic [3:0]  nib;
    logic        sh;
    logic [3:0]  an_e;
    d    = (i % 16) / 4;
    nib  = v[d*4 +: 4];
    sh   = en[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d > 0 && nib == 4'h0 && !dpv[d]) begin
      logic hz;
      hz = 1'b1;
      for (int unsigned j = d + 1; j < 4; j++)
        if (en[j] && v[j*4 +: 4] != 4'h0) hz = 1'b0;
      if (hz) sh = 1'b0;
    end
`endif
    an_e = 4'hF;
    if (sh) an_e[d] = 1'b0;
    return {(i % 16) == 15, an_e, !(sh && dpv[d]), sh ? ~TBL[nib] : 7'h7F};
  endfunction

  task automatic drive_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] en);
    bus_if.value_in = v;
    bus_if.dp_in    = dpv;
    bus_if.digit_en = en;
    bus_if.load     = 1'b1;
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    bus_if.load = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_tick, an, dp, seg} !== {1'b0, 4'hF, 1'b1, 7'h7F}) begin
      fails++;
      $display("FAIL reset: got tick/an/dp/seg=%b/%b/%b/%h expected 0/1111/1/7f",
               frame_tick, an, dp, seg);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_blank;
    logic [12:0] exp;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      exp = model(i, 16'h0, 4'h0, 4'h0);
      checks++;
      if ({frame_tick, an, dp, seg} !== exp) begin
        fails++;
        $display("FAIL idle_blank i=%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 frame_tick, an, dp, seg, exp[12], exp[11:8], exp[7], exp[6:0]);
      end
    end
  endtask

  task automatic test_hex_frame;
    logic [12:0] exp;
    drive_load(16'h12AF, 4'b0100, 4'hF);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp = (i < 16) ? model(i, 16'h0, 4'h0, 4'h0) : model(i, 16'h12AF, 4'b0100, 4'hF);
      checks++;
      if ({frame_tick, an, dp, seg} !== exp) begin
        fails++;
        $display("FAIL hex_frame i=%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 frame_tick, an, dp, seg, exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      if (i == 0) bus_if.load = 1'b0;
    end
  endtask

  task automatic test_last_write_wins;
    logic [12:0] exp;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp = (i < 16) ? model(i, 16'h12AF, 4'b0100, 4'hF) : model(i, 16'h4444, 4'h0, 4'hF);
      checks++;
      if ({frame_tick, an, dp, seg} !== exp) begin
        fails++;
        $display("FAIL last_write_wins i=%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 frame_tick, an, dp, seg, exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      if (i == 5) drive_load(16'h3333, 4'h0, 4'hF);
      if (i == 6 || i == 8) bus_if.load = 1'b0;
      if (i == 7) drive_load(16'h4444, 4'h0, 4'hF);
    end
  endtask

  task automatic test_wrap_load;
    logic [12:0] exp;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      exp = (i < 16) ? model(i, 16'h4444, 4'h0, 4'hF) : model(i, 16'h0009, 4'h0, 4'hF);
      checks++;
      if ({frame_tick, an, dp, seg} !== exp) begin
        fails++;
        $display("FAIL wrap_load i=%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 frame_tick, an, dp, seg, exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      // asserted for exactly the edge on which the scan wraps
      if (i == 14) drive_load(16'h0009, 4'h0, 4'hF);
      if (i == 15) bus_if.load = 1'b0;
    end
  endtask

  task automatic test_digit_enable;
    logic [12:0] exp;
    drive_load(16'h8888, 4'h0, 4'b0101);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp = (i < 16) ? model(i, 16'h0009, 4'h0, 4'hF) : model(i, 16'h8888, 4'h0, 4'b0101);
      checks++;
      if ({frame_tick, an, dp, seg} !== exp) begin
        fails++;
        $display("FAIL digit_enable i=%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 frame_tick, an, dp, seg, exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      if (i == 0) bus_if.load = 1'b0;
    end
  endtask

  task automatic test_zero_digits;
    logic [12:0] exp;
    drive_load(16'h0070, 4'h0, 4'hF);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i < 16)      exp = model(i, 16'h8888, 4'h0, 4'b0101);
      else if (i < 48) exp = model(i, 16'h0070, 4'h0, 4'hF);
      else             exp = model(i, 16'h0070, 4'b1000, 4'hF);
      checks++;
      if ({frame_tick, an, dp, seg} !== exp) begin
        fails++;
        $display("FAIL zero_digits i=%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 frame_tick, an, dp, seg, exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      if (i == 0 || i == 32) bus_if.load = 1'b0;
      if (i == 31) drive_load(16'h0070, 4'b1000, 4'hF);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [12:0] exp;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp = model(i, 16'h0070, 4'b1000, 4'hF);
      checks++;
      if ({frame_tick, an, dp, seg} !== exp) begin
        fails++;
        $display("FAIL pre_reset i=%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 frame_tick, an, dp, seg, exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      if (i == 2) drive_load(16'h5555, 4'hF, 4'hF);
      if (i == 3) bus_if.load = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({frame_tick, an, dp, seg} !== {1'b0, 4'hF, 1'b1, 7'h7F}) begin
      fails++;
      $display("FAIL mid_reset: got tick/an/dp/seg=%b/%b/%b/%h expected 0/1111/1/7f",
               frame_tick, an, dp, seg);
    end
    rst_n = 1'b1;
    // pending 5555 must have been discarded: display stays blank
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp = model(i, 16'h0, 4'h0, 4'h0);
      checks++;
      if ({frame_tick, an, dp, seg} !== exp) begin
        fails++;
        $display("FAIL post_reset i=%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 frame_tick, an, dp, seg, exp[12], exp[11:8], exp[7], exp[6:0]);
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus_if.value_in = '0;
    bus_if.dp_in    = '0;
    bus_if.digit_en = '0;
    bus_if.load     = 1'b0;
    test_reset();
    test_idle_blank();
    test_hex_frame();
    test_last_write_wins();
    test_wrap_load();
    test_digit_enable();
    test_zero_digits();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Multiplexed N-digit seven-segment display driver with hex decode, per-digit enable and per-digit decimal point.
- Time-multiplexes one shared seg/dp bus across DIGITS anodes at a programmable refresh rate.
- Double-buffers display data so updates take effect only at frame boundaries, which prevents tearing.
- Sits between application logic (counters, UART debug, switches) and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
CLK_HZ, 100000000, input clock frequency in Hz
REFRESH_HZ, 1000, per-digit dwell rate in Hz; DIV = CLK_HZ/REFRESH_HZ, must be >= 2
ACTIVE_LOW, 1, 1 = seg/dp/an driven active-low (board default); 0 = active-high

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
value_in  input  4*DIGITS  hex nibble per digit; nibble k drives digit k (digit 0 = rightmost)
dp_in  input  DIGITS  decimal point request per digit
digit_en  input  DIGITS  per-digit enable; 0 blanks the digit
load  input  1  one-cycle strobe; captures value_in/dp_in/digit_en
seg  output  7  segments, seg[0]=a … seg[6]=g, polarity per ACTIVE_LOW
dp  output  1  decimal point, polarity per ACTIVE_LOW
an  output  DIGITS  anode select, one-hot active, polarity per ACTIVE_LOW
frame_tick  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0

Behaviour:
- Reset (rst_n=0 at posedge):
  - prescaler=0, idx=0, pending_valid=0.
  - Active and pending registers are all zero, with enables all 0.
  - Outputs: all segments, dp and anodes inactive (ACTIVE_LOW=1: seg=7'h7F, dp=1, an=all 1s); frame_tick=0.
- Prescaler counts 0..DIV-1. At DIV-1 it returns to 0 and idx advances.
  - idx wraps DIGITS-1 -> 0.
  - frame_tick=1 in the cycle following that wrap step (registered).
- load=1:
  - value_in/dp_in/digit_en are captured into the pending registers and pending_valid=1.
  - A later load before commit overwrites pending (last write wins).
- Commit: on the cycle idx wraps to 0 with pending_valid=1, pending is copied to active and pending_valid=0.
  - load in the same cycle as the wrap commits the incoming value_in directly to active and leaves pending_valid=0.
- First display after reset: a load is required. Until then all digits remain blanked.
- Decode, active-high before polarity:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Output timing: seg/dp/an are registered and lag idx by exactly 1 clk. There are no combinational paths from inputs to outputs.
- Digit idx with active digit_en[idx]=0: anode inactive, seg all off, dp off. Blanking is never a partial or ghosted digit.
- an is never multi-hot. During the idx transition cycle the old digit stays selected until the registered update.
- Reset mid-frame returns the block to the reset state on the next edge and discards any pending data.
- The block has no handshake back-pressure: load is always accepted.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined, a digit k>0 is additionally blanked when its nibble and every higher-index enabled nibble are 0 and its dp is 0.
  - Digit 0 is never blanked by this rule.
  - Blanking is evaluated on active registers.
- When undefined, zeros are always displayed, subject only to digit_en.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - the SEG_W=7 and NIBBLE_W=4 constants;
  - the function applying ACTIVE_LOW polarity.
- One natural sub-module: seg7_hex_decode, a combinational nibble->7-bit lookup using the package table, instantiated once on the muxed nibble.
- Prescaler, scan index and double buffer stay in the top.

Test Plan:
- Bench parameters: CLK_HZ=8, REFRESH_HZ=2 (DIV=4), DIGITS=4.
1. Reset then no load -> an=4'b1111, seg=7'h7F, dp=1 for 64 clk; frame_tick every 16 clk.
2. load value_in=16'h12AF, digit_en=4'hF, dp_in=4'b0100 -> after commit, sequence over one frame:
   - an=1110 seg=~71 (F);
   - an=1101 seg=~77 (A);
   - an=1011 seg=~5B (2) with dp=0;
   - an=0111 seg=~06 (1);
   - each digit held 4 clk.
3. load 16'h3333 mid-frame, then load 16'h4444 two clk later -> displayed data unchanged until the wrap; next frame shows 4 on all digits, never 3.
4. load coincident with the wrap cycle, value 16'h0009 -> digit 0 shows 9 (seg=~6F) in the same frame, pending_valid=0.
5. digit_en=4'b0101 with 16'h8888 -> digits 1 and 3 have an inactive and seg=7'h7F; digits 0 and 2 show 8.
6. SEG7_LEADING_ZERO_BLANK_EN defined, 16'h0070 -> digits 3 and 2 blanked, digit 1 shows 7, digit 0 shows 0; with dp_in=4'b1000, digit 3 is shown.
